// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs WIDTH-bit ADD/SUB/AND/OR/NAND/NOR one bit per clock, LSB first.
// Define CMP_SIGNED_EN to make flag2 a two's-complement greater-than instead of unsigned.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             flag1,
    output logic             flag2,
    output logic             error
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpOr   = 3'b011;
    localparam logic [2:0] OpNand = 3'b100;
    localparam logic [2:0] OpNor  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             gt_q, gt_d;
    logic             any_one_q, any_one_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carryout_q, carryout_d;
    logic             flag1_q, flag1_d;
    logic             flag2_q, flag2_d;
    logic             error_q, error_d;

    logic a_bit, b_bit, bit_r, bit_c, gt_next, flag2_fin;
    logic op_legal;

    // Operands shift right each cycle, so the current bit is always at position 0.
    assign a_bit    = a_q[0];
    assign b_bit    = b_q[0];
    assign op_legal = (opcode <= OpNor);

    always_comb begin
        bit_r = 1'b0;
        bit_c = 1'b0;
        case (op_q)
            OpAdd: begin
                bit_r = a_bit ^ b_bit ^ carry_q;
                bit_c = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
            end
            OpSub: begin
                bit_r = a_bit ^ b_bit ^ carry_q;
                bit_c = (~a_bit & b_bit) | (carry_q & ~(a_bit ^ b_bit));
            end
            OpAnd:   bit_r = a_bit & b_bit;
            OpOr:    bit_r = a_bit | b_bit;
            OpNand:  bit_r = ~(a_bit & b_bit);
            OpNor:   bit_r = ~(a_bit | b_bit);
            default: bit_r = 1'b0;
        endcase
    end

    assign gt_next = (a_bit & ~b_bit) | (gt_q & ~(a_bit ^ b_bit));

`ifdef CMP_SIGNED_EN
    // On the last bit a_bit/b_bit are the sign bits; differing signs decide the compare.
    assign flag2_fin = (a_bit ^ b_bit) ? (~a_bit & b_bit) : gt_next;
`else
    assign flag2_fin = gt_next;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        gt_d       = gt_q;
        any_one_d  = any_one_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        out_d      = out_q;
        carryout_d = carryout_q;
        flag1_d    = flag1_q;
        flag2_d    = flag2_q;
        error_d    = error_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d = opcode;
                    if (op_legal) begin
                        a_d       = input1;
                        b_d       = input2;
                        cnt_d     = '0;
                        carry_d   = 1'b0;
                        gt_d      = 1'b0;
                        any_one_d = 1'b0;
                        res_d     = '0;
                        state_d   = StRun;
                    end else begin
                        out_d      = '0;
                        carryout_d = 1'b0;
                        flag1_d    = 1'b0;
                        flag2_d    = 1'b0;
                        error_d    = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StRun: begin
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                carry_d   = bit_c;
                gt_d      = gt_next;
                any_one_d = any_one_q | bit_r;
                res_d     = {bit_r, res_q[WIDTH-1:1]};
                if (cnt_q == LastCnt) begin
                    cnt_d      = '0;
                    out_d      = {bit_r, res_q[WIDTH-1:1]};
                    carryout_d = bit_c;
                    flag1_d    = ~(any_one_q | bit_r);
                    flag2_d    = flag2_fin;
                    error_d    = 1'b0;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            gt_q       <= 1'b0;
            any_one_q  <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            out_q      <= '0;
            carryout_q <= 1'b0;
            flag1_q    <= 1'b0;
            flag2_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            gt_q       <= gt_d;
            any_one_q  <= any_one_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            out_q      <= out_d;
            carryout_q <= carryout_d;
            flag1_q    <= flag1_d;
            flag2_q    <= flag2_d;
            error_q    <= error_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign out      = out_q;
    assign carryout = carryout_q;
    assign flag1    = flag1_q;
    assign flag2    = flag2_q;
    assign error    = error_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl: directed cases plus random ops vs an arithmetic model.
// Compile with the same CMP_SIGNED_EN setting as the design.
module tb_bit_serial_alu_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] input1, input2;
    logic         busy, done, carryout, flag1, flag2, error;
    logic [W-1:0] out;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] prev_out;
    logic         prev_c, prev_f1, prev_f2, prev_err;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .input1(input1), .input2(input2), .busy(busy), .done(done), .out(out),
        .carryout(carryout), .flag1(flag1), .flag2(flag2), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] o, output logic c, output logic f1,
                                  output logic f2, output logic err);
        int unsigned ai = a;
        int unsigned bi = b;
        err = 1'b0;
        c   = 1'b0;
        case (op)
            3'd0: begin o = W'(ai + bi); c = ((ai + bi) >= (1 << W)); end
            3'd1: begin o = W'(ai - bi); c = (ai < bi); end
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = ~(a & b);
            3'd5: o = ~(a | b);
            default: begin o = '0; err = 1'b1; end
        endcase
        f1 = !err && (o == 0);
`ifdef CMP_SIGNED_EN
        f2 = !err && ($signed(a) > $signed(b));
`else
        f2 = !err && (a > b);
`endif
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject);
        logic [W-1:0] e_out;
        logic e_c, e_f1, e_f2, e_err;
        int edges, busy_cnt;
        model(op, a, b, e_out, e_c, e_f1, e_f2, e_err);
        @(negedge clk);
        start = 1'b1; opcode = op; input1 = a; input2 = b;
        @(posedge clk); #1;
        // Scramble the inputs so any failure to latch shows up in the result.
        start = 1'b0; opcode = 3'($urandom); input1 = W'($urandom); input2 = W'($urandom);
        edges = 1;
        busy_cnt = 0;
        while (!done && edges < 4 * W) begin
            if (busy) busy_cnt++;
            if (edges == 2)
                check("hold_during_run", {out, carryout, flag1, flag2, error},
                      {prev_out, prev_c, prev_f1, prev_f2, prev_err});
            if (inject && edges == 3) begin
                start = 1'b1; opcode = 3'd0; input1 = ~a; input2 = a ^ b;
            end
            if (edges == 4) start = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("latency_edges", edges, e_err ? 1 : W + 1);
        check("busy_cycles", busy_cnt, e_err ? 0 : W);
        check("busy_in_done", busy, 0);
        check("out", out, e_out);
        check("carryout", carryout, e_c);
        check("flag1", flag1, e_f1);
        check("flag2", flag2, e_f2);
        check("error", error, e_err);
        // A start during DONE must be ignored.
        start = 1'b1; opcode = 3'd0; input1 = W'($urandom); input2 = W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("start_ignored_in_done", busy, 0);
        prev_out = e_out; prev_c = e_c; prev_f1 = e_f1; prev_f2 = e_f2; prev_err = e_err;
    endtask

    initial begin
        int done_hits;
        reset = 1'b1; start = 1'b0; opcode = '0; input1 = '0; input2 = '0;
        prev_out = '0; prev_c = 0; prev_f1 = 0; prev_f2 = 0; prev_err = 0;
        #2;
        check("reset_outputs", {busy, done, out, carryout, flag1, flag2, error}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_op(3'b000, 8'hFF, 8'h01, 1'b0);
        run_op(3'b001, 8'h05, 8'h07, 1'b0);
        run_op(3'b001, 8'h07, 8'h05, 1'b0);
        run_op(3'b100, 8'hF0, 8'hFF, 1'b0);
        run_op(3'b101, 8'h00, 8'h00, 1'b0);
        run_op(3'b010, 8'hAA, 8'h55, 1'b0);
        run_op(3'b110, 8'h12, 8'h34, 1'b0);
        run_op(3'b011, 8'h0C, 8'h30, 1'b0);
        run_op(3'b111, 8'h00, 8'h00, 1'b0);
        run_op(3'b010, 8'h80, 8'h7F, 1'b0);
        run_op(3'b000, 8'h3C, 8'h5A, 1'b1);
        run_op(3'b001, 8'h7F, 8'h80, 1'b1);

        // Reset in the 4th RUN cycle: outputs clear at once, no done follows.
        run_op(3'b000, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b1; opcode = 3'b001; input1 = 8'h33; input2 = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_reset_outputs", {busy, done, out, carryout, flag1, flag2, error}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        done_hits = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_hits++;
        end
        check("no_done_after_reset", done_hits, 0);
        prev_out = '0; prev_c = 0; prev_f1 = 0; prev_f2 = 0; prev_err = 0;

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
